// File: rtl/mmio_port_bank.sv
// mmio_port_bank: memory-mapped bank of synchronised input ports, byte-writable output ports
// and per-port change flags that raise a level interrupt.
module mmio_port_bank #(
  parameter int          NUM_PORTS          = 8,
  parameter logic [31:0] BASE_ADDRESS       = 32'hFFFFFFC0,
  parameter int          SYNC_STAGES        = 2,
  parameter logic [31:0] OUTPUT_RESET_VALUE = 32'h00000000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       accessRequest,
  input  logic                       accessWrite,
  input  logic [31:0]                accessAddress,
  input  logic [31:0]                writeData,
  input  logic [3:0]                 byteEnable,
  output logic [31:0]                readData,
  output logic                       accessAcknowledge,
  output logic                       accessError,
  input  logic [NUM_PORTS-1:0][31:0] mmioInputs,
  output logic [NUM_PORTS-1:0][31:0] mmioOutputs,
  output logic                       interruptRequest
);
  localparam int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(SYNC_STAGES + 2);
  logic [SYNC_STAGES-1:0][NUM_PORTS-1:0][31:0] syncChain;
  logic [NUM_PORTS-1:0][31:0] prevValue;
  logic [NUM_PORTS-1:0] changeFlags, interruptEnable, changed, clearMask;
  logic [CW-1:0] maskCount;
  logic [31:0] offset, portOffset, byteMask, maskedData, readValue;
  logic [IW-1:0] portIndex;
  logic isFlags, isEnable, isPort, valid, doWrite;
  always_comb begin
    offset = accessAddress - BASE_ADDRESS;
    portOffset = offset - 32'h20;
    portIndex = portOffset[IW+1:2];
    isFlags = offset == 32'h0;
    isEnable = offset == 32'h4;
    isPort = portOffset < 32'(4 * NUM_PORTS);
    valid = accessAddress[1:0] == 2'b00 && (isFlags || isEnable || isPort);
    doWrite = accessRequest && accessWrite && valid;
    byteMask = {{8{byteEnable[3]}}, {8{byteEnable[2]}}, {8{byteEnable[1]}}, {8{byteEnable[0]}}};
    maskedData = writeData & byteMask;
    clearMask = (doWrite && isFlags) ? maskedData[NUM_PORTS-1:0] : '0;
    readValue = isFlags ? 32'(changeFlags) : isEnable ? 32'(interruptEnable) : syncChain[SYNC_STAGES-1][portIndex];
    // changes are ignored until the chain has flushed the zeros it held during reset
    for (int i = 0; i < NUM_PORTS; i++)
      changed[i] = maskCount == '0 && syncChain[SYNC_STAGES-1][i] != prevValue[i];
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      syncChain <= '0;
      prevValue <= '0;
      changeFlags <= '0;
      interruptEnable <= '0;
      maskCount <= CW'(SYNC_STAGES + 1);
      mmioOutputs <= {NUM_PORTS{OUTPUT_RESET_VALUE}};
      readData <= '0;
      accessAcknowledge <= 1'b0;
      accessError <= 1'b0;
      interruptRequest <= 1'b0;
    end else begin
      syncChain <= {syncChain[SYNC_STAGES-2:0], mmioInputs};
      prevValue <= syncChain[SYNC_STAGES-1];
      if (maskCount != '0) maskCount <= maskCount - CW'(1);
      changeFlags <= (changeFlags & ~clearMask) | changed;
      interruptRequest <= |(changeFlags & interruptEnable);
      if (doWrite && isEnable)
        interruptEnable <= (interruptEnable & ~byteMask[NUM_PORTS-1:0]) | maskedData[NUM_PORTS-1:0];
      for (int i = 0; i < NUM_PORTS; i++)
        if (doWrite && isPort && portIndex == IW'(i))
          mmioOutputs[i] <= (mmioOutputs[i] & ~byteMask) | maskedData;
      accessAcknowledge <= accessRequest;
      accessError <= accessRequest && !valid;
      if (accessRequest) readData <= (valid && !accessWrite) ? readValue : '0;
    end
  end
endmodule

// File: tb/tb_mmio_port_bank.sv
// tb_mmio_port_bank: directed and randomized checks of mmio_port_bank against a behavioural
// model built from the register map, latency and change-flag rules.
module tb_mmio_port_bank;
  localparam int NP = 8;
  localparam int S = 2;
  localparam logic [31:0] BASE = 32'hFFFFFFC0;
  typedef logic [NP-1:0][31:0] vec_t;
  logic clock = 1'b0;
  logic reset;
  logic accessRequest, accessWrite, accessAcknowledge, accessError, interruptRequest;
  logic [31:0] accessAddress, writeData, readData;
  logic [3:0] byteEnable;
  vec_t mmioInputs, mmioOutputs;
  int total = 0;
  int passed = 0;
  vec_t mOut;
  logic [NP-1:0] mFlags, mEn;
  logic mIrq, mAck, mErr;
  logic [31:0] mRd;
  vec_t hist[$];
  int sinceRelease;

  mmio_port_bank #(.NUM_PORTS(NP), .BASE_ADDRESS(BASE), .SYNC_STAGES(S), .OUTPUT_RESET_VALUE(32'h0)) dut (
    .clock(clock), .reset(reset), .accessRequest(accessRequest), .accessWrite(accessWrite),
    .accessAddress(accessAddress), .writeData(writeData), .byteEnable(byteEnable),
    .readData(readData), .accessAcknowledge(accessAcknowledge), .accessError(accessError),
    .mmioInputs(mmioInputs), .mmioOutputs(mmioOutputs), .interruptRequest(interruptRequest)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic modelReset();
    mOut = '0;
    mFlags = '0;
    mEn = '0;
    mIrq = 0;
    mAck = 0;
    mErr = 0;
    mRd = '0;
    hist.delete();
    for (int i = 0; i <= S; i++) hist.push_back('0);
    sinceRelease = 0;
  endtask

  // One clock edge: advance the model from the inputs presented this cycle, then compare.
  task automatic step();
    vec_t fin, prv;
    logic [31:0] off, bm, md, rv;
    logic [NP-1:0] chg, clr;
    bit ok, wr;
    @(posedge clock);
    fin = hist[S-1];
    prv = hist[S];
    chg = '0;
    if (sinceRelease > S)
      for (int i = 0; i < NP; i++) chg[i] = fin[i] != prv[i];
    off = accessAddress - BASE;
    ok = accessAddress % 4 == 0 && (off == 0 || off == 4 || (off >= 32 && off < 32 + 4 * NP));
    for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{byteEnable[b]}};
    md = writeData & bm;
    wr = accessRequest && accessWrite && ok;
    rv = '0;
    if (ok && !accessWrite)
      rv = off == 0 ? 32'(mFlags) : off == 4 ? 32'(mEn) : fin[int'((off - 32) / 4)];
    clr = (wr && off == 0) ? md[NP-1:0] : '0;
    mIrq = |(mFlags & mEn);
    mFlags = (mFlags & ~clr) | chg;
    if (wr && off == 4) mEn = (mEn & ~bm[NP-1:0]) | md[NP-1:0];
    if (wr && off >= 32) mOut[int'((off - 32) / 4)] = (mOut[int'((off - 32) / 4)] & ~bm) | md;
    mAck = accessRequest;
    mErr = accessRequest && !ok;
    if (accessRequest) mRd = rv;
    hist.push_front(mmioInputs);
    void'(hist.pop_back());
    sinceRelease++;
    #1;
    check("ack", accessAcknowledge, mAck);
    check("err", accessError, mErr);
    check("readData", readData, mRd);
    check("irq", interruptRequest, mIrq);
    check("outputs", mmioOutputs, mOut);
  endtask

  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    accessRequest = 1;
    accessWrite = w;
    accessAddress = a;
    writeData = d;
    byteEnable = be;
    step();
    accessRequest = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    reset = 1;
    accessRequest = 0;
    accessWrite = 0;
    accessAddress = '0;
    writeData = '0;
    byteEnable = '0;
    mmioInputs = {NP{32'hFFFFFFFF}};
    modelReset();
    repeat (3) @(posedge clock);
    #1;
    check("reset ack", accessAcknowledge, 1'b0);
    check("reset err", accessError, 1'b0);
    check("reset readData", readData, 32'h0);
    check("reset irq", interruptRequest, 1'b0);
    check("reset outputs", mmioOutputs, vec_t'(0));
    @(negedge clock) reset = 0;
    idle(6);
    access(0, BASE, 0, 4'hF);
    check("flags masked after reset", readData, 32'h0);
    mmioInputs = '0;
    idle(5);
    access(1, BASE, 32'hFF, 4'hF);
    access(0, BASE, 0, 4'hF);
    check("flags cleared", readData, 32'h0);
    access(1, 32'hFFFFFFEC, 32'h11223344, 4'hF);
    access(1, 32'hFFFFFFEC, 32'hDEADBEEF, 4'b0101);
    check("port3 byte write", mmioOutputs[3], 32'h11AD33EF);
    check("port3 write ack", accessAcknowledge, 1'b1);
    check("port3 write err", accessError, 1'b0);
    check("write readData", readData, 32'h0);
    access(1, BASE + 32'h4, 32'h20, 4'hF);
    mmioInputs[5] = 32'h80;
    idle(3);
    check("irq lags flag", interruptRequest, 1'b0);
    access(0, BASE, 0, 4'hF);
    check("flag5 set", readData, 32'h20);
    check("irq raised", interruptRequest, 1'b1);
    access(1, BASE, 32'h20, 4'hF);
    check("irq during w1c", interruptRequest, 1'b1);
    idle(1);
    check("irq cleared", interruptRequest, 1'b0);
    access(0, BASE, 0, 4'hF);
    check("flag5 cleared", readData, 32'h0);
    access(0, BASE + 32'h34, 0, 4'hF);
    check("port5 read", readData, 32'h80);
    access(0, 32'hFFFFFFE2, 0, 4'hF);
    check("misaligned err", accessError, 1'b1);
    check("misaligned readData", readData, 32'h0);
    access(0, 32'hFFFFFFC8, 0, 4'hF);
    check("unused ack", accessAcknowledge, 1'b1);
    check("unused err", accessError, 1'b1);
    check("unused readData", readData, 32'h0);
    check("port3 untouched", mmioOutputs[3], 32'h11AD33EF);
    mmioInputs[1] = 32'h1;
    idle(2);
    access(1, BASE, 32'h02, 4'hF);
    access(0, BASE, 0, 4'hF);
    check("set beats clear", readData, 32'h02);
    for (int i = 0; i < NP; i++) mmioInputs[i] = 32'h100 + i;
    idle(4);
    for (int i = 0; i < NP; i++) begin
      access(0, BASE + 32'h20 + 4 * i, 0, 4'hF);
      check("b2b ack", accessAcknowledge, 1'b1);
      check("b2b readData", readData, 32'h100 + i);
    end
    for (int c = 0; c < 1500; c++) begin
      int k;
      if ($urandom_range(0, 7) == 0) mmioInputs[$urandom_range(0, NP - 1)] = $urandom;
      k = $urandom_range(0, 11);
      accessAddress = k == 0 ? BASE : k == 1 ? BASE + 4 : k == 2 ? BASE + 8 : k == 3 ? BASE + 12 :
                      k == 4 ? BASE + 32'h10 + 4 * $urandom_range(0, 3) :
                      k <= 8 ? BASE + 32'h20 + 4 * $urandom_range(0, NP + 1) :
                      k == 9 ? BASE + 32'h20 + $urandom_range(1, 3) : k == 10 ? $urandom : BASE - 4;
      accessRequest = $urandom_range(0, 9) < 7;
      accessWrite = $urandom_range(0, 1) == 1;
      writeData = $urandom;
      byteEnable = 4'($urandom);
      step();
    end
    accessRequest = 0;
    mmioInputs = {NP{32'hFFFFFFFF}};
    access(1, BASE + 32'h20, 32'h12345678, 4'hF);
    accessRequest = 1;
    accessWrite = 1;
    accessAddress = BASE + 32'h20;
    writeData = 32'hCAFEF00D;
    #2 reset = 1;
    modelReset();
    #1;
    check("mid-write reset outputs", mmioOutputs, vec_t'(0));
    check("mid-write reset ack", accessAcknowledge, 1'b0);
    @(negedge clock) accessRequest = 0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 0;
    idle(6);
    check("no ack after release", accessAcknowledge, 1'b0);
    access(0, BASE, 0, 4'hF);
    check("no flags from held inputs", readData, 32'h0);
    check("port0 still reset", mmioOutputs[0], 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
